// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word reads to instruction
// memory, tags in-order responses with their PC in a small FIFO and hands
// {instruction, pc} to decode. A redirect restarts fetch at a new PC and
// discards every response that was still in flight when it arrived.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instruction,
   output logic [31:0] if_pc
);

   localparam int              PW      = $clog2(BUF_DEPTH);
   localparam int              CW      = PW + 1;
   localparam logic [CW:0]     DEPTH_C = (CW + 1)'(BUF_DEPTH);
   localparam logic [CW-1:0]   ONE_C   = CW'(1);
   localparam logic [PW-1:0]   PONE_C  = PW'(1);
   localparam logic [31:0]     NOP     = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [CW-1:0]   out_q, out_d;     // requests issued, response not yet seen
   logic [CW-1:0]   drop_q, drop_d;   // responses still to be discarded
   logic [CW-1:0]   cnt_q, cnt_d;     // instruction FIFO occupancy
   logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [PW-1:0]   twr_q, twr_d, trd_q, trd_d;

   logic [31:0]     buf_instr [BUF_DEPTH];
   logic [31:0]     buf_pc    [BUF_DEPTH];
   logic [31:0]     tag_pc    [BUF_DEPTH];

   logic            fifo_nempty, req_ok, hs, rsp, dropping, push, pop;

   // The two low redirect bits carry no information: fetch is word aligned.
   logic            unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Credit is counted over both in-flight requests and buffered entries, so
   // every response is guaranteed a FIFO slot; a same-cycle pop earns nothing.
   assign fifo_nempty = (cnt_q != '0);
   assign req_ok      = (state_q == S_FETCH) &&
                        (({1'b0, out_q} + {1'b0, cnt_q}) < DEPTH_C);
   assign hs          = req_ok && imem_req_ready;
   assign rsp         = imem_rsp_valid && (out_q != '0);
   assign dropping    = rsp && (drop_q != '0);
   assign push        = rsp && !dropping && !redirect_valid;
   assign pop         = fifo_nempty && if_ready && !redirect_valid;

   assign imem_req_valid = req_ok;
   assign imem_req_addr  = pc_q;
   assign if_valid       = fifo_nempty;
   assign if_instruction = fifo_nempty ? buf_instr[rd_q] : NOP;
   assign if_pc          = fifo_nempty ? buf_pc[rd_q]    : RESET_PC;

   // Next-state: counters, pointers, PC and FSM; a redirect overrides push/pop.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      out_d   = out_q;
      drop_d  = drop_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      twr_d   = twr_q;
      trd_d   = trd_q;

      if (hs && !rsp)      out_d = out_q + ONE_C;
      else if (!hs && rsp) out_d = out_q - ONE_C;

      if (hs) begin
         pc_d  = pc_q + 32'd4;
         twr_d = twr_q + PONE_C;
      end
      if (rsp)      trd_d  = trd_q + PONE_C;
      if (push)     wr_d   = wr_q + PONE_C;
      if (pop)      rd_d   = rd_q + PONE_C;
      if (dropping) drop_d = drop_q - ONE_C;

      if (push && !pop)      cnt_d = cnt_q + ONE_C;
      else if (!push && pop) cnt_d = cnt_q - ONE_C;

      // Everything still in flight after this cycle's handshakes is stale.
      if (redirect_valid) begin
         pc_d   = {redirect_pc[31:2], 2'b00};
         drop_d = out_d;
         cnt_d  = '0;
         wr_d   = '0;
         rd_d   = '0;
      end

      case (state_q)
         S_BOOT:           state_d = S_FETCH;
         S_FETCH, S_DRAIN: state_d = (drop_d != '0) ? S_DRAIN : S_FETCH;
         default:          state_d = S_BOOT;
      endcase
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_PC;
         out_q   <= '0;
         drop_q  <= '0;
         cnt_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         twr_q   <= '0;
         trd_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         twr_q   <= twr_d;
         trd_q   <= trd_d;
      end
   end

   // Storage: PC tags of in-flight requests and the decoded-facing FIFO.
   always_ff @(posedge clk) begin
      if (hs) tag_pc[twr_q] <= pc_q;
      if (push) begin
         buf_instr[wr_q] <= imem_rsp_data;
         buf_pc[wr_q]    <= tag_pc[trd_q];
      end
   end

   // A response with nothing outstanding is a memory protocol violation.
   a_rsp_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
      !(imem_rsp_valid && (out_q == '0)));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a latency-programmable in-order memory model, a
// scoreboard of expected {pc, instruction} deliveries and request addresses,
// directed scenarios followed by a randomized run with redirects.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk, rst_n;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid, if_ready;
   logic [31:0] if_instruction, if_pc;

   fetch_stage #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready),
      .if_instruction(if_instruction), .if_pc(if_pc)
   );

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [31:0] exp_q[$];        // expected delivery PCs, in order
   logic [31:0] exp_req_addr;    // next expected request address
   logic [31:0] hs_log[$];       // request addresses accepted since last clear
   int          deliv_cnt = 0;

   logic [31:0] pend_a[$];
   int          pend_due[$];
   int          cyc = 0, last_due = 0, rsp_cnt = 0;
   int          lat_min = 1, lat_max = 1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached (got timeout, want finish)");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] memfn(input logic [31:0] a);
      if (a == 32'h0) return 32'h0030_0093;
      if (a == 32'h4) return 32'h0020_8133;
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input bit ok, input string name,
                        input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   // Expected stream after reset or redirect: contiguous words from target.
   task automatic refill(input logic [31:0] target);
      logic [31:0] t;
      t = {target[31:2], 2'b00};
      exp_req_addr = t;
      exp_q.delete();
      for (int i = 0; i < 600; i++) exp_q.push_back(t + 32'(4 * i));
   endtask

   // In-order memory: each accepted request answered after lat cycles.
   initial begin
      int d;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         imem_rsp_valid = 1'b0;
         if (rst_n && pend_a.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(pend_a.pop_front());
            void'(pend_due.pop_front());
            rsp_cnt++;
         end
         @(negedge clk);
         if (!rst_n) begin
            pend_a.delete();
            pend_due.delete();
            last_due = 0;
            imem_rsp_valid = 1'b0;
         end else if (imem_req_valid && imem_req_ready) begin
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend_a.push_back(imem_req_addr);
            pend_due.push_back(d);
            check(pend_a.size() <= DEPTH, "outstanding_bound", 32'(pend_a.size()), 32'(DEPTH));
         end
      end
   end

   // Monitor: deliveries, request addresses and held-request stability.
   initial begin
      logic [31:0] e, prev_addr;
      bit prev_held, prev_redir;
      prev_held = 1'b0;
      prev_redir = 1'b0;
      prev_addr = 32'h0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_held = 1'b0;
            prev_redir = 1'b0;
         end else begin
            if (if_valid && if_ready) begin
               if (exp_q.size() == 0) begin
                  check(1'b0, "deliv_unexpected", if_pc, 32'h0);
               end else begin
                  e = exp_q.pop_front();
                  check(if_pc == e, "deliv_pc", if_pc, e);
                  check(if_instruction == memfn(e), "deliv_instr", if_instruction, memfn(e));
               end
               deliv_cnt++;
            end
            if (imem_req_valid && imem_req_ready) begin
               check(imem_req_addr == exp_req_addr, "req_addr", imem_req_addr, exp_req_addr);
               exp_req_addr = exp_req_addr + 32'd4;
               hs_log.push_back(imem_req_addr);
            end
            if (prev_held && !prev_redir) begin
               check(imem_req_valid, "held_valid", 32'(imem_req_valid), 32'h1);
               check(imem_req_addr == prev_addr, "held_addr", imem_req_addr, prev_addr);
            end
            prev_held  = imem_req_valid && !imem_req_ready;
            prev_addr  = imem_req_addr;
            prev_redir = redirect_valid;
         end
      end
   end

   // Stimulus.
   initial begin
      bit ok, rp;
      int snap, since;
      logic [31:0] tgt;

      rst_n = 1'b0;
      imem_req_ready = 1'b1;
      if_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      refill(RESET_PC);

      // 1: reset values, boot cycle, first requests
      repeat (3) @(posedge clk);
      #1;
      check(!imem_req_valid, "rst_req_valid", 32'(imem_req_valid), 32'h0);
      check(imem_req_addr == RESET_PC, "rst_req_addr", imem_req_addr, RESET_PC);
      check(!if_valid, "rst_if_valid", 32'(if_valid), 32'h0);
      check(if_instruction == 32'h13, "rst_if_instr", if_instruction, 32'h13);
      check(if_pc == RESET_PC, "rst_if_pc", if_pc, RESET_PC);
      hs_log.delete();
      rst_n = 1'b1;
      @(negedge clk);
      check(!imem_req_valid, "boot_no_req", 32'(imem_req_valid), 32'h0);
      @(negedge clk);
      check(imem_req_valid && imem_req_addr == RESET_PC, "first_req", imem_req_addr, RESET_PC);

      // 2: streaming delivery, first two back to back
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (if_valid) ok = 1'b1;
      end
      check(ok, "stream_valid_timeout", 32'(ok), 32'h1);
      check(if_pc == 32'h0, "stream_pc0", if_pc, 32'h0);
      check(if_instruction == 32'h0030_0093, "stream_instr0", if_instruction, 32'h0030_0093);
      @(negedge clk);
      check(if_valid && if_pc == 32'h4, "stream_pc4_no_bubble", if_pc, 32'h4);
      check(if_instruction == 32'h0020_8133, "stream_instr4", if_instruction, 32'h0020_8133);
      repeat (4) @(negedge clk);
      check(hs_log.size() >= 3, "t1_req_count", 32'(hs_log.size()), 32'h3);
      if (hs_log.size() >= 3)
         for (int i = 0; i < 3; i++)
            check(hs_log[i] == 32'(4 * i), "t1_req_seq", hs_log[i], 32'(4 * i));

      // 3: backpressure from decode limits issue to the buffer depth
      @(posedge clk); #1;
      rst_n = 1'b0;
      if_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      refill(RESET_PC);
      hs_log.delete();
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check(hs_log.size() == DEPTH, "bp_req_count", 32'(hs_log.size()), 32'(DEPTH));
      check(!imem_req_valid, "bp_req_stalled", 32'(imem_req_valid), 32'h0);
      check(if_valid && if_pc == RESET_PC, "bp_head", if_pc, RESET_PC);
      @(posedge clk); #1;
      if_ready = 1'b1;
      repeat (20) @(posedge clk);
      check(hs_log.size() > DEPTH, "bp_resume", 32'(hs_log.size()), 32'(DEPTH + 1));

      // 4: redirect with two requests outstanding
      lat_min = 4;
      lat_max = 4;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(posedge clk); #2;
         if (pend_a.size() == 2 && !imem_req_valid && !imem_rsp_valid) ok = 1'b1;
      end
      check(ok, "rd_two_outstanding", 32'(pend_a.size()), 32'h2);
      snap = rsp_cnt;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      refill(32'h0000_0100);
      hs_log.delete();
      @(negedge clk);
      check(!if_valid, "rd_flushed", 32'(if_valid), 32'h0);
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (hs_log.size() > 0) ok = 1'b1;
      end
      check(ok, "rd_req_timeout", 32'(ok), 32'h1);
      if (ok) check(hs_log[0] == 32'h100, "rd_first_req", hs_log[0], 32'h100);
      check(rsp_cnt - snap >= 2, "rd_drained_first", 32'(rsp_cnt - snap), 32'h2);
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (if_valid) ok = 1'b1;
      end
      check(ok && if_pc == 32'h100, "rd_first_if_pc", if_pc, 32'h100);

      // 5: PC wraps past the top of the address space
      @(posedge clk); #1;
      lat_min = 1;
      lat_max = 1;
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      refill(32'hFFFF_FFF8);
      hs_log.delete();
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (hs_log.size() >= 3) ok = 1'b1;
      end
      check(ok, "wrap_req_count", 32'(hs_log.size()), 32'h3);
      if (ok) begin
         check(hs_log[0] == 32'hFFFF_FFF8, "wrap_req0", hs_log[0], 32'hFFFF_FFF8);
         check(hs_log[1] == 32'hFFFF_FFFC, "wrap_req1", hs_log[1], 32'hFFFF_FFFC);
         check(hs_log[2] == 32'h0000_0000, "wrap_req2", hs_log[2], 32'h0000_0000);
      end

      // 6: reset while the FIFO is full
      @(posedge clk); #1;
      if_ready = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check(if_valid, "mid_full_valid", 32'(if_valid), 32'h1);
      check(!imem_req_valid, "mid_full_no_req", 32'(imem_req_valid), 32'h0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check(!if_valid, "mid_rst_if_valid", 32'(if_valid), 32'h0);
      check(!imem_req_valid, "mid_rst_req_valid", 32'(imem_req_valid), 32'h0);
      check(imem_req_addr == RESET_PC, "mid_rst_addr", imem_req_addr, RESET_PC);
      if_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      refill(RESET_PC);
      hs_log.delete();
      rst_n = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (hs_log.size() > 0) ok = 1'b1;
      end
      check(ok, "mid_restart_timeout", 32'(ok), 32'h1);
      if (ok) check(hs_log[0] == RESET_PC, "mid_restart_addr", hs_log[0], RESET_PC);

      // Randomized traffic with redirects.
      lat_min = 1;
      lat_max = 3;
      rp = 1'b0;
      since = 0;
      tgt = 32'h0;
      snap = deliv_cnt;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (rp) begin
            redirect_valid = 1'b0;
            refill(tgt);
            rp = 1'b0;
         end
         imem_req_ready = ($urandom_range(3, 0) != 0);
         if_ready = ($urandom_range(3, 0) != 0);
         since++;
         if (since > 150 || $urandom_range(29, 0) == 0) begin
            tgt = $urandom;
            redirect_valid = 1'b1;
            redirect_pc = tgt;
            rp = 1'b1;
            since = 0;
         end
      end
      @(posedge clk); #1;
      if (rp) begin
         redirect_valid = 1'b0;
         refill(tgt);
      end
      imem_req_ready = 1'b1;
      if_ready = 1'b1;
      lat_min = 1;
      lat_max = 1;
      repeat (40) @(posedge clk);
      check(deliv_cnt - snap > 500, "rand_throughput", 32'(deliv_cnt - snap), 32'd501);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
